// File: rtl/periph_reset_seq_if.sv
// periph_reset_seq_if
//   Shared 8-bit CSR bus as seen by one register block.
//   csr_a   5-bit register address
//   csr_di  8-bit write data
//   csr_we  one-cycle write strobe
//   csr_do  8-bit read data; 8'h00 from a block that is not addressed, so
//           the parent can OR every block's csr_do together
//   master: bus owner (drives address/data/strobe, reads csr_do)
//   slave : register block (samples address/data/strobe, drives csr_do)
interface periph_reset_seq_if;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do;

   modport master (output csr_a, output csr_di, output csr_we, input csr_do);
   modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface

// File: rtl/periph_reset_seq.sv
// periph_reset_seq
//   Staggered peripheral reset sequencer. After a start (port pulse or CSR
//   write of bit7 to BASE_ADDR) it releases NUM_STEPS reset lines one at a
//   time, STEP_DELAY ce ticks apart (0 means 256). Lines flagged in
//   hold_mask stay in reset but still consume their step slot. An abort
//   (port pulse or CSR bit6) reasserts every line at once and wins over a
//   simultaneous start.
//
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   ce         one-cycle timebase tick
//   start      one-cycle pulse: begin a full sequence from step 0
//   abort      one-cycle pulse: reassert all lines, return to idle
//   hold_mask  1 = keep line i in reset regardless of the sequence
//   csr        CSR bus slave; BASE_ADDR = ctrl/status, BASE_ADDR+1 = lines
//   rst_out    1 = line i held in reset (registered)
//   busy       sequence in progress
//   done       last sequence completed without abort
module periph_reset_seq #(
   parameter logic [4:0] BASE_ADDR  = 5'h1d,
   parameter int         NUM_STEPS  = 6,
   parameter logic [7:0] STEP_DELAY = 8'd4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_STEPS-1:0] hold_mask,
   periph_reset_seq_if.slave    csr,
   output logic [NUM_STEPS-1:0] rst_out,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [4:0]           LINE_ADDR = BASE_ADDR + 5'd1;
   localparam logic [2:0]           LAST_IDX  = 3'(NUM_STEPS - 1);
   localparam logic [NUM_STEPS-1:0] ONE       = NUM_STEPS'(1);

   state_t               state_q, state_d;
   logic [NUM_STEPS-1:0] released_q, released_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           cnt_q, cnt_d;

   logic base_hit;
   logic line_hit;
   logic go;
   logic stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         released_q <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         rst_out    <= '1;
      end else begin
         state_q    <= state_d;
         released_q <= released_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         // Built from the next released value so abort and each release
         // show up one clk after their cause; hold_mask is taken as-is so
         // a mask change also lands one clk later.
         rst_out    <= ~released_d | hold_mask;
      end
   end

   always_comb begin
      state_d    = state_q;
      released_d = released_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;

      base_hit = csr.csr_we && (csr.csr_a == BASE_ADDR);
      line_hit = csr.csr_we && (csr.csr_a == LINE_ADDR);
      go       = start | (base_hit & csr.csr_di[7]);
      stop     = abort | (base_hit & csr.csr_di[6]);

      case (state_q)
         WAIT: begin
            if (ce) begin
               // cnt wraps through zero, so a STEP_DELAY of 0 waits 256 ticks
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  released_d = released_q | (ONE << idx_q);
                  if (idx_q == LAST_IDX) begin
                     state_d = DONE;
                  end else begin
                     idx_d = idx_q + 3'd1;
                     cnt_d = STEP_DELAY;
                  end
               end
            end
         end
         default: ;
      endcase

      // Software reassert of individual lines; FSM state is untouched, so a
      // running sequence may release the line again at its slot.
      if (line_hit)
         released_d = released_d & ~csr.csr_di[NUM_STEPS-1:0];

      // Abort is checked first so it wins over any start in the same cycle;
      // a ce arriving with start is discarded by the overwrite of cnt.
      if (stop) begin
         released_d = '0;
         state_d    = IDLE;
      end else if (go) begin
         released_d = '0;
         idx_d      = '0;
         cnt_d      = STEP_DELAY;
         state_d    = WAIT;
      end
   end

   assign busy = (state_q == WAIT);
   assign done = (state_q == DONE);

   always_comb begin
      csr.csr_do = 8'h00;
      if (csr.csr_a == BASE_ADDR)
         csr.csr_do = {busy, done, 3'b000, idx_q};
      else if (csr.csr_a == LINE_ADDR)
         csr.csr_do = 8'(rst_out);
   end

endmodule
